// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio path types and constants
package audio_pkg;
   localparam int DEFAULT_SAMPLE_WIDTH = 16;
   localparam int UNDERRUN_W = 8;

   typedef struct packed {
      logic [DEFAULT_SAMPLE_WIDTH-1:0] left;   // 31:16
      logic [DEFAULT_SAMPLE_WIDTH-1:0] right;  // 15:0
   } stereo_frame_t;

   typedef enum logic [1:0] {
      UNSYNC = 2'd0,
      LEFT   = 2'd1,
      RIGHT  = 2'd2
   } slot_state_t;
endpackage

// File: rtl/i2s_dac_serializer_if.sv
// rtl/i2s_dac_serializer_if.sv - parallel stereo frame handshake into the serializer
interface i2s_dac_serializer_if #(
   parameter int W = audio_pkg::DEFAULT_SAMPLE_WIDTH
) ();
   logic [2*W-1:0] audio_in;
   logic           audio_valid;
   logic           audio_ready;

   modport master (output audio_in, output audio_valid, input audio_ready);
   modport slave  (input audio_in, input audio_valid, output audio_ready);
endinterface

// File: rtl/lrck_edge_detect.sv
// rtl/lrck_edge_detect.sv - LRCK fall/rise pulses against the previous-edge sample
module lrck_edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic lrck,
   output logic fall,
   output logic rise
);
   logic lrck_q;

   // Resetting high makes a low LRCK at release look like a fall.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) lrck_q <= 1'b1;
      else      lrck_q <= lrck;
   end

   assign fall = lrck_q & ~lrck;
   assign rise = ~lrck_q & lrck;
endmodule

// File: rtl/i2s_dac_serializer.sv
// rtl/i2s_dac_serializer.sv - buffers stereo frames and shifts them out as I2S
module i2s_dac_serializer
   import audio_pkg::*;
#(
   parameter int SAMPLE_WIDTH    = audio_pkg::DEFAULT_SAMPLE_WIDTH,
   parameter bit UNDERRUN_REPEAT = 1'b1
) (
   input  logic                  AUD_BCLK,
   input  logic                  rst,
   input  logic                  AUD_DACLRCK,
   i2s_dac_serializer_if.slave   aud,
   output logic                  AUD_DACDAT,
   output logic                  frame_start,
   output logic                  channel,
   output logic [UNDERRUN_W-1:0] underrun_count
);
   localparam int W  = SAMPLE_WIDTH;
   localparam int CW = $clog2(W + 1);

   logic           fall, rise;
   slot_state_t    state;
   logic           hold_full, ready_q;
   logic [2*W-1:0] holding, last_frame, next_frame;
   logic [W-1:0]   shreg;
   logic [CW-1:0]  bit_cnt;
   logic           write, frame_go;

   lrck_edge_detect u_edge (
      .clk  (AUD_BCLK),
      .rst  (rst),
      .lrck (AUD_DACLRCK),
      .fall (fall),
      .rise (rise)
   );

   assign aud.audio_ready = ready_q;
   assign write      = aud.audio_valid && ready_q;
   assign frame_go   = fall && (state != LEFT);
   assign next_frame = hold_full ? holding : (UNDERRUN_REPEAT ? last_frame : '0);

   always_ff @(posedge AUD_BCLK or negedge rst) begin
      if (!rst) begin
         state          <= UNSYNC;
         hold_full      <= 1'b0;
         ready_q        <= 1'b1;
         holding        <= '0;
         last_frame     <= '0;
         shreg          <= '0;
         bit_cnt        <= '0;
         AUD_DACDAT     <= 1'b0;
         frame_start    <= 1'b0;
         channel        <= 1'b0;
         underrun_count <= '0;
      end else begin
         frame_start <= 1'b0;
         if (frame_go) begin
            // A write landing with an empty-holding frame start feeds the next frame, never this one.
            hold_full <= write;
            ready_q   <= !write;
            if (write) holding <= aud.audio_in;
            if (!hold_full && underrun_count != '1)
               underrun_count <= underrun_count + UNDERRUN_W'(1);
            last_frame  <= next_frame;
            shreg       <= next_frame[2*W-1:W];
            AUD_DACDAT  <= next_frame[2*W-1];
            bit_cnt     <= '0;
            frame_start <= 1'b1;
            state       <= LEFT;
            channel     <= 1'b0;
         end else begin
            if (write) begin
               holding   <= aud.audio_in;
               hold_full <= 1'b1;
               ready_q   <= 1'b0;
            end
            if (state == LEFT && rise) begin
               state      <= RIGHT;
               channel    <= 1'b1;
               shreg      <= last_frame[W-1:0];
               AUD_DACDAT <= last_frame[W-1];
               bit_cnt    <= '0;
            end else if ((state == LEFT && fall) || (state == RIGHT && rise)) begin
               state      <= UNSYNC;
               channel    <= 1'b0;
               AUD_DACDAT <= 1'b0;
            end else if (state == UNSYNC) begin
               AUD_DACDAT <= 1'b0;
            end else if (bit_cnt != CW'(W)) begin
               // Zero padding once the sample is out keeps wide slots quiet.
               bit_cnt    <= bit_cnt + CW'(1);
               AUD_DACDAT <= (bit_cnt < CW'(W - 1)) ? shreg[W-2] : 1'b0;
               shreg      <= shreg << 1;
            end
         end
      end
   end
endmodule

// File: tb/tb_i2s_dac_serializer.sv
// tb/tb_i2s_dac_serializer.sv - directed bench, repeat and zero-fill underrun variants side by side
module tb_i2s_dac_serializer;
   import audio_pkg::*;

   logic        bclk, rst, lrck, vld;
   logic [31:0] din;
   logic        dacdat_a, fs_a, ch_a, dacdat_b, fs_b, ch_b;
   logic [7:0]  und_a, und_b;
   logic        ready_a;

   int n_total = 0, n_pass = 0, n_fail = 0;

   logic [31:0] ba, bb;
   int          fs;
   logic        ch, r0, r1, bit_a, bit_b;

   i2s_dac_serializer_if ifa ();
   i2s_dac_serializer_if ifb ();

   assign ifa.audio_in    = din;
   assign ifa.audio_valid = vld;
   assign ifb.audio_in    = din;
   assign ifb.audio_valid = vld;
   assign ready_a         = ifa.audio_ready;

   i2s_dac_serializer #(.SAMPLE_WIDTH(16), .UNDERRUN_REPEAT(1'b1)) dut_a (
      .AUD_BCLK(bclk), .rst(rst), .AUD_DACLRCK(lrck), .aud(ifa),
      .AUD_DACDAT(dacdat_a), .frame_start(fs_a), .channel(ch_a), .underrun_count(und_a));

   i2s_dac_serializer #(.SAMPLE_WIDTH(16), .UNDERRUN_REPEAT(1'b0)) dut_b (
      .AUD_BCLK(bclk), .rst(rst), .AUD_DACLRCK(lrck), .aud(ifb),
      .AUD_DACDAT(dacdat_b), .frame_start(fs_b), .channel(ch_b), .underrun_count(und_b));

   initial begin
      bclk = 1'b0;
      forever #5 bclk = ~bclk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   // One 32-BCLK slot; LRCK changes at the calling negedge, bits sampled at each following negedge.
   task automatic slot(input logic lv, input logic [31:0] nd,
                       output logic [31:0] oa, output logic [31:0] ob,
                       output int fsc, output logic och, output logic or0, output logic or1);
      lrck = lv;
      fsc  = 0;
      for (int i = 0; i < 32; i++) begin
         @(negedge bclk);
         oa[31-i] = dacdat_a;
         ob[31-i] = dacdat_b;
         if (fs_a) fsc++;
         if (i == 0) begin
            och = ch_a;
            or0 = ready_a;
            din = nd;
         end
         if (i == 1) or1 = ready_a;
      end
   endtask

   initial begin
      rst = 1'b0; lrck = 1'b0; vld = 1'b0; din = '0;
      repeat (3) @(negedge bclk);
      chk("rst_dacdat", {31'd0, dacdat_a}, 32'd0);
      chk("rst_ready", {31'd0, ready_a}, 32'd1);
      chk("rst_frame_start", {31'd0, fs_a}, 32'd0);
      chk("rst_channel", {31'd0, ch_a}, 32'd0);
      chk("rst_underrun", {24'd0, und_a}, 32'd0);

      lrck = 1'b1;
      @(negedge bclk);
      rst = 1'b1;
      @(negedge bclk);
      vld = 1'b1; din = 32'hA5A5_0F0F;
      @(negedge bclk);
      vld = 1'b0;
      chk("ready_after_write", {31'd0, ready_a}, 32'd0);
      chk("unsync_dacdat", {31'd0, dacdat_a}, 32'd0);
      @(negedge bclk);

      // frame 1: written data
      slot(1'b0, 32'd0, ba, bb, fs, ch, r0, r1);
      chk("f1_fs", fs, 1);
      chk("f1_left", ba, 32'hA5A5_0000);
      chk("f1_left_ch", {31'd0, ch}, 32'd0);
      chk("f1_ready", {31'd0, r0}, 32'd1);
      slot(1'b1, 32'd0, ba, bb, fs, ch, r0, r1);
      chk("f1_right", ba, 32'h0F0F_0000);
      chk("f1_right_ch", {31'd0, ch}, 32'd1);
      chk("f1_right_fs", fs, 0);
      chk("f1_underrun", {24'd0, und_a}, 32'd0);

      // frame 2: underrun, repeat vs zero fill
      slot(1'b0, 32'd0, ba, bb, fs, ch, r0, r1);
      chk("f2_left_rep", ba, 32'hA5A5_0000);
      chk("f2_left_zero", bb, 32'h0);
      slot(1'b1, 32'd0, ba, bb, fs, ch, r0, r1);
      chk("f2_right_rep", ba, 32'h0F0F_0000);
      chk("f2_right_zero", bb, 32'h0);
      chk("f2_underrun_a", {24'd0, und_a}, 32'd1);
      chk("f2_underrun_b", {24'd0, und_b}, 32'd1);

      // frame 3: write coincides with the fall while holding is empty
      vld = 1'b1; din = 32'h8001_7FFE;
      slot(1'b0, 32'hDEAD_BEEF, ba, bb, fs, ch, r0, r1);
      chk("f3_left_rep", ba, 32'hA5A5_0000);
      chk("f3_left_zero", bb, 32'h0);
      chk("f3_ready", {31'd0, r0}, 32'd0);
      slot(1'b1, 32'hDEAD_BEEF, ba, bb, fs, ch, r0, r1);
      chk("f3_underrun_a", {24'd0, und_a}, 32'd2);
      chk("f3_underrun_b", {24'd0, und_b}, 32'd2);

      // frames 4-6: valid held high
      slot(1'b0, 32'h0123_FFFF, ba, bb, fs, ch, r0, r1);
      chk("f4_left", ba, 32'h8001_0000);
      chk("f4_left_b", bb, 32'h8001_0000);
      chk("f4_ready0", {31'd0, r0}, 32'd1);
      chk("f4_ready1", {31'd0, r1}, 32'd0);
      slot(1'b1, 32'h0123_FFFF, ba, bb, fs, ch, r0, r1);
      chk("f4_right", ba, 32'h7FFE_0000);
      slot(1'b0, 32'h0123_FFFF, ba, bb, fs, ch, r0, r1);
      chk("f5_left", ba, 32'h0123_0000);
      chk("f5_ready1", {31'd0, r1}, 32'd0);
      vld = 1'b0;
      slot(1'b1, 32'h0123_FFFF, ba, bb, fs, ch, r0, r1);
      chk("f5_right", ba, 32'hFFFF_0000);
      slot(1'b0, 32'd0, ba, bb, fs, ch, r0, r1);
      chk("f6_left", ba, 32'h0123_0000);
      chk("f6_ready", {31'd0, r0}, 32'd1);
      slot(1'b1, 32'd0, ba, bb, fs, ch, r0, r1);
      chk("f6_right", ba, 32'hFFFF_0000);
      chk("f6_underrun", {24'd0, und_a}, 32'd2);

      // frame 7: reset at bit 7 of the left slot
      lrck = 1'b0;
      bit_a = 1'b0; bit_b = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge bclk);
         if (i == 7) begin
            bit_a = dacdat_a;
            bit_b = dacdat_b;
         end
      end
      chk("f7_bit7_a", {31'd0, bit_a}, 32'd1);
      chk("f7_bit7_b", {31'd0, bit_b}, 32'd0);
      chk("f7_underrun", {24'd0, und_a}, 32'd3);
      rst = 1'b0;
      #1;
      chk("mid_rst_dacdat", {31'd0, dacdat_a}, 32'd0);
      chk("mid_rst_underrun", {24'd0, und_a}, 32'd0);
      chk("mid_rst_ready", {31'd0, ready_a}, 32'd1);
      @(negedge bclk);
      lrck = 1'b1;
      @(negedge bclk);
      rst = 1'b1;
      @(negedge bclk);
      vld = 1'b1; din = 32'hC003_5AA5;
      @(negedge bclk);
      vld = 1'b0;
      chk("post_rst_ready", {31'd0, ready_a}, 32'd0);
      slot(1'b1, 32'd0, ba, bb, fs, ch, r0, r1);
      chk("unsync_slot_data", ba, 32'h0);
      chk("unsync_slot_fs", fs, 0);
      chk("unsync_slot_ch", {31'd0, ch}, 32'd0);
      slot(1'b0, 32'd0, ba, bb, fs, ch, r0, r1);
      chk("f8_fs", fs, 1);
      chk("f8_left", ba, 32'hC003_0000);
      chk("f8_underrun", {24'd0, und_a}, 32'd0);
      slot(1'b1, 32'd0, ba, bb, fs, ch, r0, r1);
      chk("f8_right", ba, 32'h5AA5_0000);

      // 300 frames without data
      for (int k = 0; k < 300; k++) begin
         slot(1'b0, 32'd0, ba, bb, fs, ch, r0, r1);
         slot(1'b1, 32'd0, ba, bb, fs, ch, r0, r1);
         if (k == 253) chk("sat_254", {24'd0, und_a}, 32'd254);
         if (k == 254) chk("sat_255", {24'd0, und_a}, 32'd255);
      end
      chk("sat_final_a", {24'd0, und_a}, 32'd255);
      chk("sat_final_b", {24'd0, und_b}, 32'd255);
      chk("sat_right_rep", ba, 32'h5AA5_0000);
      chk("sat_right_zero", bb, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
